// File: rtl/dma_arb.sv
// dma_arb: shares the memory port between the 65C02 core and one DMA master.
// Stalls the core with RDY, grants bounded DMA bursts, then replays the stalled read.
module dma_arb #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned MIN_CPU   = 4
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [15:0] cpu_AD,
  input  logic [7:0]  cpu_DO,
  input  logic        cpu_WE,
  output logic        RDY,
  input  logic        dma_req,
  input  logic [15:0] dma_AD,
  input  logic [7:0]  dma_DO,
  input  logic        dma_WE,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [15:0] AD,
  output logic [7:0]  DO,
  output logic        WE
);

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_DMA     = 2'd1,
    S_RESTORE = 2'd2
  } state_t;

  localparam logic [7:0] L_MAX  = 8'(MAX_BURST);
  localparam logic [7:0] L_COOL = 8'(MIN_CPU - 1);

  state_t      r_state;
  logic [7:0]  r_burst;
  logic [7:0]  r_cool;
  logic [15:0] r_save_ad;
  logic        r_rvalid;

  logic        w_take;
  logic        w_end;

  // Only a core read may be interrupted; writes always reach memory.
  assign w_take = dma_req & ~cpu_WE & (r_cool == 8'd0);
  assign w_end  = ~dma_req | (r_burst == L_MAX);

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_CPU;
      r_burst   <= 8'd0;
      r_cool    <= 8'd0;
      r_save_ad <= 16'd0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= (r_state == S_DMA) & ~dma_WE;
      unique case (r_state)
        S_CPU: begin
          if (w_take) begin
            r_state   <= S_DMA;
            r_save_ad <= cpu_AD;
            r_burst   <= 8'd1;
          end else if (r_cool != 8'd0) begin
            r_cool <= r_cool - 8'd1;
          end
        end
        S_DMA: begin
          if (w_end) begin
            r_state <= S_RESTORE;
          end else begin
            r_burst <= r_burst + 8'd1;
          end
        end
        S_RESTORE: begin
          r_state <= S_CPU;
          r_cool  <= L_COOL;
        end
        default: begin
          r_state <= S_CPU;
        end
      endcase
    end
  end

  assign RDY        = (r_state == S_CPU);
  assign dma_gnt    = (r_state == S_DMA);
  assign dma_rvalid = r_rvalid;

  // RESTORE re-reads the saved address so DI is valid when RDY returns.
  always_comb begin
    AD = cpu_AD;
    DO = cpu_DO;
    WE = cpu_WE;
    unique case (r_state)
      S_DMA: begin
        AD = dma_AD;
        DO = dma_DO;
        WE = dma_WE;
      end
      S_RESTORE: begin
        AD = r_save_ad;
        WE = 1'b0;
      end
      default: begin
        AD = cpu_AD;
      end
    endcase
  end

endmodule

// File: doc/dma_arb.md
# dma_arb

Memory-bus arbiter between the 65C02 core and one DMA master. It sits between the core's combinatorial address/data-out/write-enable outputs and the memory port. It stalls the core with RDY, hands the bus to DMA in bounded bursts, and replays the core's interrupted read before releasing it. This guarantees the core sees the correct DI when it resumes.

## Interface
- MAX_BURST, 16, maximum consecutive DMA cycles per grant (1..255)
- MIN_CPU, 4, minimum consecutive core cycles with RDY=1 between grants (1..255)

- clk  in  1  system clock; all state changes on rising edge
- RST_N  in  1  reset; asynchronous, active-low
- cpu_AD  in  16  core address (combinatorial from core)
- cpu_DO  in  8  core write data
- cpu_WE  in  1  core write enable
- RDY  out  1  core ready; 0 freezes core
- dma_req  in  1  DMA wants the bus; held high while it has transfers pending
- dma_AD  in  16  DMA address, valid while dma_gnt=1
- dma_DO  in  8  DMA write data
- dma_WE  in  1  DMA write enable
- dma_gnt  out  1  DMA owns the bus this cycle; one transfer per gnt cycle
- dma_rvalid  out  1  DI holds read data for the previous DMA read
- AD  out  16  memory address
- DO  out  8  memory write data
- WE  out  1  memory write enable

## Operation
- States: CPU, DMA, RESTORE. Counters: burst (8 bit), cool (8 bit). Registers: SAVE_AD (16 bit), rvalid.
- CPU state:
  - RDY=1, dma_gnt=0.
  - AD/DO/WE = cpu_AD/cpu_DO/cpu_WE.
- DMA state:
  - RDY=0, dma_gnt=1.
  - AD/DO/WE = dma_AD/dma_DO/dma_WE.
- RESTORE state:
  - RDY=0, dma_gnt=0.
  - AD=SAVE_AD, DO=cpu_DO, WE=0.
- CPU → DMA at the clock edge when all of the following hold in the current cycle:
  - dma_req=1
  - cpu_WE=0 (a core write is never interrupted)
  - cool=0

  On that edge: SAVE_AD <= cpu_AD, burst <= 1.
- DMA → RESTORE when dma_req=0 or burst=MAX_BURST. Otherwise stay in DMA with burst <= burst+1.
  - dma_req is sampled each DMA cycle.
  - The transfer in the cycle where dma_req falls is still performed, because dma_gnt=1 in that cycle. DMA masters must deassert dma_req in the same cycle as their last transfer.
- RESTORE → CPU unconditionally after 1 cycle, cool <= MIN_CPU-1.
- In CPU state, cool decrements each cycle while non-zero and saturates at 0.
- rvalid <= dma_gnt & ~dma_WE. DMA captures DI in the cycle rvalid=1.
- The RESTORE cycle re-reads SAVE_AD, so on return to CPU, DI holds the data for the read the core had in flight. The core resumes exactly where it stalled.
- A core write is never suppressed or replayed: grants start only after read cycles, and RDY is 1 whenever core WE reaches memory.

## Timing
- Reset (RST_N=0, asynchronous): state=CPU, RDY=1, dma_gnt=0, dma_rvalid=0, burst=0, cool=0, SAVE_AD=0. AD/DO/WE follow the core immediately.
- Reset mid-burst: dma_gnt drops and the bus returns to the core without a RESTORE cycle. The core is reset by the same event.
- Grant latency:
  - dma_req high in a core read cycle n with cool=0 gives dma_gnt=1 in cycle n+1.
  - If cycle n is a core write, the grant is deferred to the first following read cycle.
- Burst length: 1..MAX_BURST gnt cycles.
- Stall per grant: RDY=0 for (burst length + 1) cycles.
- Fairness: after each RESTORE, at least MIN_CPU cycles with RDY=1, then the first read cycle with dma_req=1 triggers a grant.
- dma_rvalid is 1 cycle after each DMA read gnt cycle. It may coincide with the RESTORE cycle.
- All outputs except RDY/dma_gnt/dma_rvalid are combinatorial from inputs plus state. RDY, dma_gnt and dma_rvalid are decoded from registers only.

## Test plan
- Reset: hold RST_N=0 with cpu_AD=0x1234, cpu_WE=0 and dma_req=1 -> RDY=1, dma_gnt=0, AD=0x1234, WE=0. After release with cool=0, dma_gnt=1 next cycle.
- Single transfer: cycle n cpu_AD=0xC010 (read) with dma_req=1, then dma_req=0 in cycle n+1 with dma_AD=0x0200, dma_WE=1, dma_DO=0x5A ->
  - cycle n+1: AD=0x0200, WE=1, DO=0x5A, RDY=0.
  - cycle n+2: AD=0xC010, WE=0, RDY=0.
  - cycle n+3: RDY=1.
- Write deferral: dma_req=1 during a core write cycle to 0x01FD -> no grant on that edge. WE=1 reaches memory with RDY=1. Grant follows the next read cycle.
- Burst limit (MAX_BURST=4, MIN_CPU=4): dma_req held high ->
  - repeating pattern of 4 gnt cycles, 1 RESTORE cycle, then 4 cycles with RDY=1 (all core reads);
  - dma_rvalid=1 after each DMA read.
- Reset mid-burst: RST_N pulled low during the 2nd gnt cycle -> dma_gnt=0 and RDY=1 in the same cycle, with no clock edge needed. No RESTORE cycle occurs.
- Cooldown with writes: MIN_CPU=2, core issues 2 writes then a read after RESTORE while dma_req=1 -> grant only after the read. cool stays at 0 and the grant is not lost.
